qam_p2s: RTL and testbench

QAM_P2S -- requirements
Module: qam_p2s

---
 rtl/qam_pkg.sv | 28 ++
 rtl/qam_p2s_if.sv | 58 +++++
 rtl/qam_sym_fifo.sv | 78 +++++++
 rtl/qam_p2s.sv | 163 ++++++++++++++++
 tb/tb_qam_p2s.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/qam_pkg.sv
// ---------------------------------------------------------------------------
// qam_pkg
// Shared definitions for the QAM4 parallel-to-serial datapath.
//   sym_t        : 2-bit QAM4 symbol, bit I_BIT = I sign, bit Q_BIT = Q sign
//   I_BIT/Q_BIT  : positions of the I and Q sign bits inside a symbol
//   ser_state_t  : serializer state (IDLE / SEND_Q)
//   level_width  : width of a FIFO occupancy counter for a given depth
// Optional build macro used by files importing this package:
//   QAM_P2S_OVF_CNT_EN -- adds the 8-bit saturating overflow counter
// ---------------------------------------------------------------------------
package qam_pkg;

   typedef logic [1:0] sym_t;

   localparam int I_BIT = 0;
   localparam int Q_BIT = 1;

   typedef enum logic {
      IDLE   = 1'b0,
      SEND_Q = 1'b1
   } ser_state_t;

   // Occupancy must be able to represent the value DEPTH itself, hence +1.
   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/qam_p2s_if.sv
// ---------------------------------------------------------------------------
// qam_p2s_if
// Bundles the symbol input handshake, the bit-rate strobe and the serial /
// status outputs of qam_p2s.
//   master modport : the symbol source / bit clock side (drives sym_valid,
//                    sym_in, data_change; observes everything else)
//   slave  modport : qam_p2s itself
// Signals:
//   sym_valid, sym_in, sym_ready : symbol push handshake
//   data_change                  : one-cycle bit-rate strobe
//   adat_ki_S, bit_valid         : registered serial bit and its qualifier
//   fifo_level, ovf, underrun    : status
//   ovf_cnt                      : only with QAM_P2S_OVF_CNT_EN defined
// ---------------------------------------------------------------------------
interface qam_p2s_if
   import qam_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) ();

   localparam int LVL_W = level_width(FIFO_DEPTH);

   logic             sym_valid;
   sym_t             sym_in;
   logic             sym_ready;
   logic             data_change;
   logic             adat_ki_S;
   logic             bit_valid;
   logic [LVL_W-1:0] fifo_level;
   logic             ovf;
   logic             underrun;
`ifdef QAM_P2S_OVF_CNT_EN
   logic [7:0]       ovf_cnt;
`endif

`ifdef QAM_P2S_OVF_CNT_EN
   modport master (
      output sym_valid, sym_in, data_change,
      input  sym_ready, adat_ki_S, bit_valid, fifo_level, ovf, underrun, ovf_cnt
   );

   modport slave (
      input  sym_valid, sym_in, data_change,
      output sym_ready, adat_ki_S, bit_valid, fifo_level, ovf, underrun, ovf_cnt
   );
`else
   modport master (
      output sym_valid, sym_in, data_change,
      input  sym_ready, adat_ki_S, bit_valid, fifo_level, ovf, underrun
   );

   modport slave (
      input  sym_valid, sym_in, data_change,
      output sym_ready, adat_ki_S, bit_valid, fifo_level, ovf, underrun
   );
`endif

endinterface

// File: rtl/qam_sym_fifo.sv
// ---------------------------------------------------------------------------
// qam_sym_fifo
// Synchronous symbol FIFO, DEPTH entries (power of two, 2..16).
// Ports:
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   push, push_data  : write request (ignored when full)
//   pop,  pop_data   : read request (ignored when empty); pop_data always
//                      shows the current head entry
//   level            : occupancy 0..DEPTH
//   full, empty      : decoded from level
// The head is read straight from storage, so a word written this cycle only
// becomes visible at the head in the next cycle (no write-to-read bypass).
// ---------------------------------------------------------------------------
module qam_sym_fifo
   import qam_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          push,
   input  sym_t                          push_data,
   input  logic                          pop,
   output sym_t                          pop_data,
   output logic [level_width(DEPTH)-1:0] level,
   output logic                          full,
   output logic                          empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = level_width(DEPTH);

   sym_t             mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Requests are qualified here so the caller cannot corrupt the FIFO by
   // pushing when full or popping when empty.
   always_comb begin
      full     = (level == LVL_W'(DEPTH));
      empty    = (level == '0);
      do_push  = push && !full;
      do_pop   = pop && !empty;
      pop_data = mem[rd_ptr];
   end

   // Pointers are exactly log2(DEPTH) bits wide, so incrementing past the last
   // entry wraps to zero naturally.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   // Storage is not reset: the pointers and level alone define what is valid.
   always_ff @(posedge clock) begin
      if (!reset && do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/qam_p2s.sv
// ---------------------------------------------------------------------------
// qam_p2s
// QAM4 parallel-to-serial converter. Symbols are queued in a small FIFO and
// shifted out one bit per data_change strobe, I sign first, then Q sign.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : sym_valid/sym_in/sym_ready push handshake, data_change
//                  strobe, adat_ki_S/bit_valid serial output, fifo_level,
//                  sticky ovf, one-cycle underrun pulse
// Parameter:
//   FIFO_DEPTH   : symbol FIFO depth (power of two, 2..16)
// Build option:
//   QAM_P2S_OVF_CNT_EN -- adds bus.ovf_cnt, an 8-bit saturating count of
//                         dropped symbols
// ---------------------------------------------------------------------------
module qam_p2s
   import qam_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic      clock,
   input  logic      reset,
   qam_p2s_if.slave  bus
);

   localparam int LVL_W = level_width(FIFO_DEPTH);

   ser_state_t       state_q;
   ser_state_t       state_d;
   logic             adat_q;
   logic             adat_d;
   logic             bit_valid_q;
   logic             bit_valid_d;
   logic             underrun_q;
   logic             underrun_d;
   logic             q_hold_q;
   logic             q_hold_d;
   logic             ovf_q;
   logic             fifo_pop;
   logic             fifo_push;
   logic             fifo_full;
   logic             fifo_empty;
   logic             drop;
   sym_t             fifo_head;
   logic [LVL_W-1:0] fifo_level;

   // Push side. Ready is derived from the level before any same-cycle pop,
   // so a push into a full FIFO is dropped even if a strobe frees a slot.
   always_comb begin
      bus.sym_ready = !fifo_full;
      fifo_push     = bus.sym_valid && !fifo_full;
      drop          = bus.sym_valid && fifo_full;
   end

   qam_sym_fifo #(
      .DEPTH     (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (bus.sym_in),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .level     (fifo_level),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Serializer state and registered outputs. Reset drops any held Q bit so
   // no half symbol leaks out afterwards.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         adat_q      <= 1'b0;
         bit_valid_q <= 1'b0;
         underrun_q  <= 1'b0;
         q_hold_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         adat_q      <= adat_d;
         bit_valid_q <= bit_valid_d;
         underrun_q  <= underrun_d;
         q_hold_q    <= q_hold_d;
      end
   end

   // Next-state logic: a strobe in IDLE starts a symbol only if one is
   // queued; a strobe in SEND_Q always finishes the symbol.
   always_comb begin
      state_d = state_q;
      if (bus.data_change) begin
         case (state_q)
            IDLE:    state_d = fifo_empty ? IDLE : SEND_Q;
            SEND_Q:  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Output logic: between strobes the serial bit and its qualifier hold.
   // An empty-FIFO strobe keeps the old bit level but marks it invalid and
   // flags an underrun for exactly one cycle.
   always_comb begin
      adat_d      = adat_q;
      bit_valid_d = bit_valid_q;
      underrun_d  = 1'b0;
      q_hold_d    = q_hold_q;
      fifo_pop    = 1'b0;
      if (bus.data_change) begin
         case (state_q)
            IDLE: begin
               if (!fifo_empty) begin
                  fifo_pop    = 1'b1;
                  adat_d      = fifo_head[I_BIT];
                  q_hold_d    = fifo_head[Q_BIT];
                  bit_valid_d = 1'b1;
               end else begin
                  bit_valid_d = 1'b0;
                  underrun_d  = 1'b1;
               end
            end
            SEND_Q: begin
               adat_d      = q_hold_q;
               bit_valid_d = 1'b1;
            end
            default: begin
               bit_valid_d = 1'b0;
            end
         endcase
      end
   end

   // Sticky overflow flag: only reset clears it.
   always_ff @(posedge clock) begin
      if (reset) begin
         ovf_q <= 1'b0;
      end else if (drop) begin
         ovf_q <= 1'b1;
      end
   end

`ifdef QAM_P2S_OVF_CNT_EN
   logic [7:0] ovf_cnt_q;

   // Counts dropped symbols, holding at 255 instead of wrapping.
   always_ff @(posedge clock) begin
      if (reset) begin
         ovf_cnt_q <= 8'd0;
      end else if (drop && (ovf_cnt_q != 8'hFF)) begin
         ovf_cnt_q <= ovf_cnt_q + 8'd1;
      end
   end

   assign bus.ovf_cnt = ovf_cnt_q;
`endif

   assign bus.adat_ki_S  = adat_q;
   assign bus.bit_valid  = bit_valid_q;
   assign bus.underrun   = underrun_q;
   assign bus.ovf        = ovf_q;
   assign bus.fifo_level = fifo_level;

endmodule

// File: tb/tb_qam_p2s.sv
// ---------------------------------------------------------------------------
// tb_qam_p2s
// Self-checking bench for qam_p2s (FIFO_DEPTH = 4). A queue-based reference
// model (symbol queue + pending serial bit queue) runs alongside the DUT and
// is compared on every cycle; directed sequences add literal expectations,
// and a serial-to-parallel model reassembles the bit stream for the
// streaming test. Honours QAM_P2S_OVF_CNT_EN.
// ---------------------------------------------------------------------------
module tb_qam_p2s;
   import qam_pkg::*;

   localparam int DEPTH = 4;

   logic clock;
   logic reset;

   qam_p2s_if #(.FIFO_DEPTH(DEPTH)) bus ();

   qam_p2s #(
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int compared   = 0;
   int mismatched = 0;

   // Reference model state
   sym_t m_fifo [$];
   bit   m_pend [$];
   bit   m_adat;
   bit   m_bv;
   bit   m_und;
   bit   m_ovf;
   int   m_cnt;
   bit   m_new_bit;

   // Compare / S2P control
   bit   check_en = 0;
   bit   s2p_en   = 0;
   bit   rx_bits [$];
   int   s2p_underruns;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input bit valid, input sym_t sym, input bit strobe,
                                input bit rst);
      reset           = rst;
      bus.sym_valid   = valid;
      bus.sym_in      = sym;
      bus.data_change = strobe;
      @(posedge clock);
      #1;
   endtask

   // Reference model: symbols wait in a queue; a strobe with no bit pending
   // expands the head symbol into its I,Q bit pair, then emits one bit.
   always @(posedge clock) begin
      bit pre_full;
      sym_t s;
      m_new_bit = 0;
      if (reset) begin
         m_fifo.delete();
         m_pend.delete();
         m_adat = 0;
         m_bv   = 0;
         m_und  = 0;
         m_ovf  = 0;
         m_cnt  = 0;
      end else begin
         pre_full = (m_fifo.size() == DEPTH);
         m_und = 0;
         if (bus.data_change) begin
            if (m_pend.size() == 0 && m_fifo.size() != 0) begin
               s = m_fifo.pop_front();
               m_pend.push_back(s[0]);
               m_pend.push_back(s[1]);
            end
            if (m_pend.size() != 0) begin
               m_adat    = m_pend.pop_front();
               m_bv      = 1;
               m_new_bit = 1;
            end else begin
               m_bv  = 0;
               m_und = 1;
            end
         end
         if (bus.sym_valid) begin
            if (!pre_full) begin
               m_fifo.push_back(bus.sym_in);
            end else begin
               m_ovf = 1;
               if (m_cnt < 255) m_cnt++;
            end
         end
      end
   end

   // Per-cycle comparison against the model, plus the S2P capture.
   always @(negedge clock) begin
      if (check_en) begin
         checkOutput("adat_ki_S", 32'(bus.adat_ki_S), 32'(m_adat));
         checkOutput("bit_valid", 32'(bus.bit_valid), 32'(m_bv));
         checkOutput("underrun", 32'(bus.underrun), 32'(m_und));
         checkOutput("ovf", 32'(bus.ovf), 32'(m_ovf));
         checkOutput("fifo_level", 32'(bus.fifo_level), 32'(m_fifo.size()));
         checkOutput("sym_ready", 32'(bus.sym_ready), 32'(m_fifo.size() != DEPTH));
`ifdef QAM_P2S_OVF_CNT_EN
         checkOutput("ovf_cnt", 32'(bus.ovf_cnt), 32'(m_cnt));
`endif
      end
      if (s2p_en) begin
         if (m_new_bit && bus.bit_valid) rx_bits.push_back(bus.adat_ki_S);
         if (bus.underrun && rx_bits.size() > 0 && rx_bits.size() < 40) s2p_underruns++;
      end
   end

   initial begin
      sym_t seq3 [3];
      bit   exp_bits [6];
      sym_t sent [$];
      int   idx;
      int   cyc;
      sym_t rs;

      $display("[TB] start");
      applyStimulus(0, 2'b00, 0, 1);
      check_en = 1;
      applyStimulus(0, 2'b00, 0, 1);

      // Reset state
      checkOutput("rst_adat", 32'(bus.adat_ki_S), 32'd0);
      checkOutput("rst_bit_valid", 32'(bus.bit_valid), 32'd0);
      checkOutput("rst_underrun", 32'(bus.underrun), 32'd0);
      checkOutput("rst_ovf", 32'(bus.ovf), 32'd0);
      checkOutput("rst_level", 32'(bus.fifo_level), 32'd0);
      applyStimulus(0, 2'b00, 0, 0);
      checkOutput("rst_ready", 32'(bus.sym_ready), 32'd1);

      // Strobe on empty FIFO after reset
      applyStimulus(0, 2'b00, 1, 0);
      checkOutput("empty_und", 32'(bus.underrun), 32'd1);
      checkOutput("empty_bv", 32'(bus.bit_valid), 32'd0);
      checkOutput("empty_adat", 32'(bus.adat_ki_S), 32'd0);
      applyStimulus(0, 2'b00, 0, 0);
      checkOutput("empty_und_pulse", 32'(bus.underrun), 32'd0);

      // Three symbols then six strobes: 01,10,11 -> 1,0,0,1,1,1
      seq3 = '{2'b01, 2'b10, 2'b11};
      exp_bits = '{1, 0, 0, 1, 1, 1};
      applyStimulus(0, 2'b00, 0, 1);
      for (int i = 0; i < 3; i++) applyStimulus(1, seq3[i], 0, 0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(0, 2'b00, 1, 0);
         checkOutput($sformatf("seq_bit%0d", i), 32'(bus.adat_ki_S), 32'(exp_bits[i]));
         checkOutput($sformatf("seq_bv%0d", i), 32'(bus.bit_valid), 32'd1);
      end

      // Five pushes, no strobes: fill then overflow
      applyStimulus(0, 2'b00, 0, 1);
      applyStimulus(1, 2'b01, 0, 0);
      applyStimulus(1, 2'b10, 0, 0);
      applyStimulus(1, 2'b11, 0, 0);
      applyStimulus(1, 2'b00, 0, 0);
      checkOutput("full_ready", 32'(bus.sym_ready), 32'd0);
      checkOutput("full_ovf_pre", 32'(bus.ovf), 32'd0);
      applyStimulus(1, 2'b11, 0, 0);
      checkOutput("full_ovf", 32'(bus.ovf), 32'd1);
      checkOutput("full_level", 32'(bus.fifo_level), 32'd4);
`ifdef QAM_P2S_OVF_CNT_EN
      checkOutput("full_ovf_cnt", 32'(bus.ovf_cnt), 32'd1);
`endif

      // Full FIFO, push + strobe together: push dropped, head (01) sent
      applyStimulus(1, 2'b11, 1, 0);
      checkOutput("pp_ovf", 32'(bus.ovf), 32'd1);
      checkOutput("pp_level", 32'(bus.fifo_level), 32'd3);
      checkOutput("pp_adat", 32'(bus.adat_ki_S), 32'd1);
      checkOutput("pp_bv", 32'(bus.bit_valid), 32'd1);

      // Reset while Q bit of 2'b10 is held
      applyStimulus(0, 2'b00, 0, 1);
      applyStimulus(1, 2'b10, 0, 0);
      applyStimulus(0, 2'b00, 1, 0);
      checkOutput("mid_i_bit", 32'(bus.adat_ki_S), 32'd0);
      applyStimulus(1, 2'b11, 1, 1);
      checkOutput("mid_rst_bv", 32'(bus.bit_valid), 32'd0);
      checkOutput("mid_rst_level", 32'(bus.fifo_level), 32'd0);
      applyStimulus(0, 2'b00, 1, 0);
      checkOutput("mid_und", 32'(bus.underrun), 32'd1);
      checkOutput("mid_adat", 32'(bus.adat_ki_S), 32'd0);
      applyStimulus(0, 2'b00, 1, 0);
      checkOutput("mid_adat2", 32'(bus.adat_ki_S), 32'd0);
      checkOutput("mid_bv2", 32'(bus.bit_valid), 32'd0);

      // Streaming: 20 random symbols, strobe every 3 cycles, one push per
      // two strobes after a two-symbol prefill, reassembled by S2P.
      applyStimulus(0, 2'b00, 0, 1);
      rx_bits.delete();
      s2p_underruns = 0;
      s2p_en = 1;
      for (int i = 0; i < 2; i++) begin
         rs = sym_t'($urandom_range(3));
         sent.push_back(rs);
         applyStimulus(1, rs, 0, 0);
      end
      idx = 2;
      cyc = 0;
      while (rx_bits.size() < 40 && cyc < 300) begin
         if ((cyc % 6) == 1 && idx < 20) begin
            rs = sym_t'($urandom_range(3));
            sent.push_back(rs);
            idx++;
            applyStimulus(1, rs, (cyc % 3) == 0, 0);
         end else begin
            applyStimulus(0, 2'b00, (cyc % 3) == 0, 0);
         end
         cyc++;
      end
      s2p_en = 0;
      checkOutput("s2p_bit_count", 32'(rx_bits.size()), 32'd40);
      checkOutput("s2p_underruns", 32'(s2p_underruns), 32'd0);
      for (int i = 0; i < 20; i++) begin
         sym_t got;
         got = (2 * i + 1 < rx_bits.size()) ? {rx_bits[2*i+1], rx_bits[2*i]} : 2'bxx;
         checkOutput($sformatf("s2p_sym%0d", i), 32'(got), 32'(sent[i]));
      end

      // Random traffic against the model, including occasional resets
      applyStimulus(0, 2'b00, 0, 1);
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(1) == 1, sym_t'($urandom_range(3)),
                       $urandom_range(4) < 2, $urandom_range(63) == 0);
      end

      check_en = 0;
      @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
